lfsr_burst_ctrl: RTL and testbench
==================================

// Module: lfsr_burst_ctrl
// PURPOSE
//  Sequencer for the PRBS datapath. Accepts a start command with seed and burst length, then steps an
//  internal LFSR core (Fibonacci or Galois) once per accepted word. Streams burst_len words out over a
//  valid/ready interface, then pulses done. Guards against the all-zero lock-up state.
//  Sits between the test-pattern host and downstream consumers (e.g. the BER checker) as the pattern source.
// PARAMETERS
//  LENGTH  16                    LFSR/word width; bit order [0:LENGTH-1]
//  TAPS    16'b0110100000000000  Tap mask, index 0 = MSB of literal
//  TYPE    1                     0 = Fibonacci, 1 = Galois
//  CNT_W   16                    Width of burst_len / words_sent
// PORTS
//  clk         in   1         System clock, rising edge
//  rst         in   1         Async active-low reset
//  start       in   1         Begin burst; sampled in IDLE only
//  seed        in   LENGTH    Initial LFSR state, captured with start
//  burst_len   in   CNT_W     Words to emit, captured with start
//  abort       in   1         Terminate burst early
//  m_valid     out  1         Output word valid
//  m_ready     in   1         Consumer ready
//  m_data      out  LENGTH    Current LFSR state
//  busy        out  1         High in RUN and DONE
//  done        out  1         One-cycle pulse at end of burst (normal or aborted)
//  aborted     out  1         Valid with done: burst ended by abort
//  lockup_err  out  1         Sticky; cleared on next accepted start
//  words_sent  out  CNT_W     Handshakes completed in current/last burst
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, lfsr=0, m_valid=0, m_data=0, busy=0, done=0, aborted=0, lockup_err=0, words_sent=0.
//  FSM: IDLE -> RUN -> DONE -> IDLE. All outputs registered.
//  IDLE:
//   - start=1 at edge N: lfsr<=seed, words_sent<=0, lockup_err<=0.
//   - If burst_len!=0: RUN, with m_valid=1 after edge N; the first word is the seed.
//   - If burst_len==0: go straight to DONE, no words.
//   - seed==0: load 1 instead (Galois/Fibonacci: lfsr[LENGTH-1]=1) and set lockup_err.
//  RUN:
//   - Handshake = m_valid & m_ready. On each handshake: lfsr steps once, words_sent++.
//   - m_data/m_valid held stable while m_valid & !m_ready.
//   - Handshake making words_sent==burst_len: next state DONE, m_valid<=0.
//  Galois step: o=s[LENGTH-1]; n[0]=o; n[i]=s[i-1]^(TAPS[i]&o) for i>=1.
//  Fibonacci step: f=XOR of s[i] where TAPS[i]=1; n={f,s[0:LENGTH-2]}.
//  Lock-up: if the stepped value is 0, load 1 instead and set lockup_err; the burst continues.
//  abort=1 in RUN:
//   - Next state DONE, m_valid<=0, aborted<=1.
//   - A handshake in the same cycle still counts.
//   - If that handshake is the final word, aborted=0 (normal completion wins).
//  abort in IDLE or DONE: ignored. start outside IDLE: ignored.
//  DONE: done=1 for exactly one cycle, then IDLE. aborted and words_sent hold until next start.
//  Counter width: burst_len up to 2^CNT_W-1; words_sent never wraps within a burst.
//  Async reset mid-burst: immediate return to reset values. Any partial burst is discarded.
// TESTING
//  1 Galois, seed=16'd1, len=3, m_ready=1 -> m_data 16'h0001, 16'hE800, 16'h7400 on 3 consecutive cycles; done pulses 1 cycle later; words_sent=3.
//  2 Same, m_ready toggling 1/0 -> identical sequence; m_data stable while stalled; 3 handshakes; done after third.
//  3 seed=0, len=2 -> first word 16'h0001, lockup_err=1 through DONE, cleared by next start.
//  4 len=100, abort after 10 handshakes (with ready high) -> 11 words accepted (abort cycle counts), done+aborted, m_valid low next cycle.
//  5 burst_len=0 -> no m_valid, done one cycle after start. start pulsed during RUN -> ignored.
//  6 Fibonacci, TAPS=16'b0110100000000001, seed=1, len=65535 -> no repeat of seed before the last word; rst low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_burst_ctrl.sv
// PRBS burst sequencer: loads a seed, then streams burst_len LFSR words over valid/ready and pulses done.
// Vectors use [0:LENGTH-1] ordering, so TAPS index 0 is the MSB of the literal.
module lfsr_burst_ctrl #(
    parameter int                LENGTH = 16,
    parameter logic [0:LENGTH-1] TAPS   = 16'b0110100000000000,
    parameter int                TYPE   = 1,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [0:LENGTH-1] seed,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              abort,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [0:LENGTH-1] m_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              lockup_err,
    output logic [CNT_W-1:0]  words_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [0:LENGTH-1] ONE = {{(LENGTH-1){1'b0}}, 1'b1};

    state_t            state;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  ws_inc;
    logic [0:LENGTH-1] stepped;
    logic              step_zero;
    logic              hs;

    function automatic logic [0:LENGTH-1] lfsr_step(input logic [0:LENGTH-1] s);
        logic [0:LENGTH-1] n;
        logic              fb;
        n  = '0;
        fb = 1'b0;
        if (TYPE == 1) begin
            fb   = s[LENGTH-1];
            n[0] = fb;
            for (int i = 1; i < LENGTH; i++) begin
                n[i] = s[i-1] ^ (TAPS[i] & fb);
            end
        end else begin
            fb = ^(s & TAPS);
            n  = {fb, s[0:LENGTH-2]};
        end
        return n;
    endfunction

    assign hs        = m_valid & m_ready;
    assign ws_inc    = words_sent + CNT_W'(1);
    assign stepped   = lfsr_step(m_data);
    assign step_zero = (stepped == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len_q      <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            lockup_err <= 1'b0;
            words_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q      <= burst_len;
                        words_sent <= '0;
                        aborted    <= 1'b0;
                        busy       <= 1'b1;
                        // An all-zero seed would lock the register, so substitute 1 and flag it
                        if (seed == '0) begin
                            m_data     <= ONE;
                            lockup_err <= 1'b1;
                        end else begin
                            m_data     <= seed;
                            lockup_err <= 1'b0;
                        end
                        if (burst_len != '0) begin
                            state   <= RUN;
                            m_valid <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        m_data     <= step_zero ? ONE : stepped;
                        words_sent <= ws_inc;
                        if (step_zero) begin
                            lockup_err <= 1'b1;
                        end
                    end
                    // The final handshake takes priority over a coincident abort
                    if (hs && (ws_inc == len_q)) begin
                        state   <= DONE;
                        m_valid <= 1'b0;
                        done    <= 1'b1;
                    end else if (abort) begin
                        state   <= DONE;
                        m_valid <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl: a Galois and a Fibonacci instance checked cycle by cycle against a
// transaction-level model, plus literal expectations for the directed scenarios.
module tb_lfsr_burst_ctrl;

    localparam logic [15:0] G_TAPS = 16'h6800;
    localparam logic [15:0] F_TAPS = 16'h6801;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_g = 1'b0;
    logic        start_f = 1'b0;
    logic [15:0] seed = '0;
    logic [15:0] burst_len = '0;
    logic        abort = 1'b0;
    logic        m_ready = 1'b0;
    bit          sel = 1'b0;

    logic        g_valid, g_busy, g_done, g_abt, g_lock;
    logic [15:0] g_data, g_ws;
    logic        f_valid, f_busy, f_done, f_abt, f_lock;
    logic [15:0] f_data, f_ws;

    lfsr_burst_ctrl #(.LENGTH(16), .TAPS(16'b0110100000000000), .TYPE(1), .CNT_W(16)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .seed(seed), .burst_len(burst_len), .abort(abort),
        .m_valid(g_valid), .m_ready(m_ready), .m_data(g_data), .busy(g_busy), .done(g_done),
        .aborted(g_abt), .lockup_err(g_lock), .words_sent(g_ws)
    );

    lfsr_burst_ctrl #(.LENGTH(16), .TAPS(16'b0110100000000001), .TYPE(0), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .seed(seed), .burst_len(burst_len), .abort(abort),
        .m_valid(f_valid), .m_ready(m_ready), .m_data(f_data), .busy(f_busy), .done(f_done),
        .aborted(f_abt), .lockup_err(f_lock), .words_sent(f_ws)
    );

    always #5 clk = ~clk;

    logic        a_valid, a_busy, a_done, a_abt, a_lock, a_start;
    logic [15:0] a_data, a_ws;
    assign a_valid = sel ? f_valid : g_valid;
    assign a_busy  = sel ? f_busy  : g_busy;
    assign a_done  = sel ? f_done  : g_done;
    assign a_abt   = sel ? f_abt   : g_abt;
    assign a_lock  = sel ? f_lock  : g_lock;
    assign a_data  = sel ? f_data  : g_data;
    assign a_ws    = sel ? f_ws    : g_ws;
    assign a_start = sel ? start_f : start_g;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Integer view of the register: literal MSB (index 0) is bit 15, so each step is a right shift.
    function automatic logic [15:0] model_next(input logic [15:0] v, input bit fib);
        logic [15:0] r;
        if (fib) begin
            r     = v >> 1;
            r[15] = ^(v & F_TAPS);
        end else begin
            r     = (v >> 1) ^ (v[0] ? G_TAPS : 16'h0000);
            r[15] = v[0];
        end
        return r;
    endfunction

    // Model state
    bit          exp_valid = 0, exp_done = 0, exp_lock = 0, exp_abt = 0, stall = 0;
    int          hs_count = 0;
    int          done_seen = 0;
    int          repeats = 0;
    int          start_cyc = 0, done_cyc = 0;
    logic [15:0] exp_word = '0, first_word = '0, stall_data = '0, exp_len = '0;
    logic [15:0] got_words[$];

    always @(negedge clk) begin
        bit nx_done;
        if (!rst) begin
            exp_valid = 0; exp_done = 0; exp_lock = 0; exp_abt = 0; stall = 0;
            hs_count  = 0;
        end else begin
            chk("m_valid", a_valid, exp_valid);
            chk("done", a_done, exp_done);
            chk("busy", a_busy, exp_valid | exp_done);
            chk("words_sent", a_ws, hs_count);
            chk("lockup_err", a_lock, exp_lock);
            if (exp_done) begin
                chk("aborted", a_abt, exp_abt);
                done_seen++;
                done_cyc = cyc;
            end
            if (stall) chk("stall_hold", a_data, stall_data);
            nx_done = 0;
            stall   = 0;
            if (exp_valid) begin
                if (m_ready) begin
                    chk("m_data", a_data, exp_word);
                    got_words.push_back(a_data);
                    if (hs_count > 0 && a_data == first_word) repeats++;
                    hs_count++;
                    exp_word = model_next(exp_word, sel);
                    if (exp_word == 16'h0000) begin
                        exp_word = 16'h0001;
                        exp_lock = 1;
                    end
                    if (hs_count == int'(exp_len)) begin
                        exp_valid = 0; nx_done = 1; exp_abt = 0;
                    end else if (abort) begin
                        exp_valid = 0; nx_done = 1; exp_abt = 1;
                    end
                end else if (abort) begin
                    exp_valid = 0; nx_done = 1; exp_abt = 1;
                end else begin
                    stall      = 1;
                    stall_data = a_data;
                end
            end else if (!exp_done && a_start) begin
                exp_word   = (seed == 16'h0000) ? 16'h0001 : seed;
                first_word = exp_word;
                exp_lock   = (seed == 16'h0000);
                exp_abt    = 0;
                hs_count   = 0;
                exp_len    = burst_len;
                start_cyc  = cyc;
                got_words.delete();
                if (burst_len != 16'h0000) exp_valid = 1;
                else nx_done = 1;
            end
            exp_done = nx_done;
        end
    end

    task automatic go(input logic [15:0] s, input logic [15:0] len);
        @(posedge clk); #1;
        seed = s;
        burst_len = len;
        if (sel) start_f = 1'b1;
        else start_g = 1'b1;
        @(posedge clk); #1;
        start_f = 1'b0;
        start_g = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int d0;
        int k;
        d0 = done_seen;
        k  = 0;
        while (done_seen == d0 && k < budget) begin
            @(posedge clk); #1;
            if (toggle) m_ready = ~m_ready;
            k++;
        end
        if (done_seen == d0) chk("done_timeout", 0, 1);
    endtask

    task automatic do_reset(input bit s);
        @(posedge clk); #1;
        rst = 1'b0;
        sel = s;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        // Reset values on both instances
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_g_valid", g_valid, 0);
        chk("rst_g_data", g_data, 0);
        chk("rst_g_busy", g_busy, 0);
        chk("rst_g_done", g_done, 0);
        chk("rst_g_ws", g_ws, 0);
        chk("rst_f_data", f_data, 0);
        chk("rst_f_lock", f_lock, 0);
        rst = 1'b1;

        // 1: Galois seed 1, three words, ready high
        m_ready = 1'b1;
        go(16'h0001, 16'd3);
        wait_done(20, 0);
        chk("t1_count", got_words.size(), 3);
        chk("t1_w0", got_words[0], 16'h0001);
        chk("t1_w1", got_words[1], 16'hE800);
        chk("t1_w2", got_words[2], 16'h7400);
        chk("t1_latency", done_cyc - start_cyc, 4);
        chk("t1_ws", g_ws, 3);
        chk("t1_aborted", g_abt, 0);

        // 2: same burst with ready toggling
        m_ready = 1'b0;
        go(16'h0001, 16'd3);
        wait_done(40, 1);
        m_ready = 1'b1;
        chk("t2_count", got_words.size(), 3);
        chk("t2_w1", got_words[1], 16'hE800);
        chk("t2_w2", got_words[2], 16'h7400);
        chk("t2_ws", g_ws, 3);

        // 3: zero seed substitutes 1 and flags lock-up until the next start
        go(16'h0000, 16'd2);
        wait_done(20, 0);
        chk("t3_w0", got_words[0], 16'h0001);
        chk("t3_w1", got_words[1], 16'hE800);
        chk("t3_lock_held", g_lock, 1);
        go(16'h0005, 16'd1);
        chk("t3_lock_clr", g_lock, 0);
        wait_done(20, 0);

        // 4: abort coinciding with the 11th handshake
        go(16'hACE1, 16'd100);
        repeat (10) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t4_ws", g_ws, 11);
        chk("t4_done", g_done, 1);
        chk("t4_aborted", g_abt, 1);
        chk("t4_valid", g_valid, 0);
        @(posedge clk); #1;
        chk("t4_abt_hold", g_abt, 1);
        chk("t4_ws_hold", g_ws, 11);

        // 4b: abort on the final word is a normal completion
        go(16'h0001, 16'd2);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("t4b_aborted", g_abt, 0);
        chk("t4b_ws", g_ws, 2);

        // 5: zero-length burst, then start ignored while running
        go(16'h1234, 16'd0);
        chk("t5_done", g_done, 1);
        chk("t5_valid", g_valid, 0);
        @(posedge clk); #1;
        chk("t5_latency", done_cyc - start_cyc, 1);
        m_ready = 1'b0;
        go(16'hACE1, 16'd4);
        @(posedge clk); #1;
        seed = 16'h0BAD;
        burst_len = 16'd1;
        start_g = 1'b1;
        @(posedge clk); #1;
        start_g = 1'b0;
        m_ready = 1'b1;
        wait_done(20, 0);
        chk("t5_ws", g_ws, 4);
        chk("t5_w0", got_words[0], 16'hACE1);

        // 6: Fibonacci full period, then reset mid-burst
        do_reset(1'b1);
        go(16'h0001, 16'd2);
        wait_done(20, 0);
        chk("t6_fw1", got_words[1], 16'h8000);
        repeats = 0;
        go(16'h0001, 16'hFFFF);
        wait_done(70000, 0);
        chk("t6_ws", f_ws, 65535);
        chk("t6_repeats", repeats, 0);
        go(16'h00FF, 16'd50);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", f_valid, 0);
        chk("t6_rst_data", f_data, 0);
        chk("t6_rst_busy", f_busy, 0);
        chk("t6_rst_done", f_done, 0);
        chk("t6_rst_ws", f_ws, 0);
        chk("t6_rst_abt", f_abt, 0);
        chk("t6_rst_lock", f_lock, 0);
        @(posedge clk); #1 rst = 1'b1;
        go(16'h0001, 16'd2);
        wait_done(20, 0);
        chk("t6_after_rst", got_words[1], 16'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
